// File: rtl/ibuffer_fifo.sv
// Instruction buffer between fetch (writer) and decode (reader): a parametrised circular FIFO
// with registered one-cycle read strobe, occupancy status and sticky overflow/underflow flags.
module ibuffer_fifo #(
  parameter int WIDTH     = 7,
  parameter int DEPTH     = 6,
  parameter int AFULL_LVL = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wren,
  input  logic [WIDTH-1:0] instr_in,
  input  logic             rden,
  output logic [WIDTH-1:0] instr_out,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             rd_acc;
  logic             wr_acc;

  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AFULL_CNT);

  // A write into a full buffer is only legal when a read frees a slot in the same cycle.
  assign rd_acc = rden & ~empty;
  assign wr_acc = wren & (~full | rd_acc);

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Storage carries no reset; it is only written on an accepted, non-flushed write.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc) begin
      mem[wr_ptr] <= instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      instr_out <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= next_ptr(wr_ptr);
      end

      // The read port is a strobe: data is zeroed on every cycle without an accepted read.
      if (rd_acc) begin
        instr_out <= mem[rd_ptr];
        out_valid <= 1'b1;
        rd_ptr    <= next_ptr(rd_ptr);
      end else begin
        instr_out <= '0;
        out_valid <= 1'b0;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (wren && !wr_acc) begin
        ovf <= 1'b1;
      end
      if (rden && empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule
